sumador_rizado: RTL and testbench

- Registered N-bit ripple-carry adder built structurally from a chain of WIDTH full-adder cells; the carry ripples LSB to MSB.
- Sits under the adder power-dissipation bench as the ripple-carry candidate, fed 8-bit operands with carry-in tied to 0.
- Includes a built-in output transition counter for switching-activity (power) estimation.

---
 rtl/sumador_rizado_if.sv | 30 +++
 rtl/sumador_rizado.sv | 101 ++++++++++
 tb/tb_sumador_rizado.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sumador_rizado_if.sv
`default_nettype none
// ============================================================================
// Module   : sumador_rizado_if
// Purpose  : Operand/result bundle for the registered ripple-carry adder.
// Revision : 1.0
// ============================================================================
interface sumador_rizado_if #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 32
);
   logic [WIDTH-1:0]     oprA;
   logic [WIDTH-1:0]     oprB;
   logic                 cin;
   logic                 clr_cnt;
   logic [WIDTH-1:0]     Suma;
   logic                 carry;
   logic                 ovf;
   logic [CNT_WIDTH-1:0] transiciones;

   modport master (
      output oprA, oprB, cin, clr_cnt,
      input  Suma, carry, ovf, transiciones
   );

   modport slave (
      input  oprA, oprB, cin, clr_cnt,
      output Suma, carry, ovf, transiciones
   );
endinterface
`default_nettype wire

// File: rtl/sumador_rizado.sv
`default_nettype none
// ============================================================================
// Module   : sumador_rizado
// Purpose  : Registered ripple-carry adder with output toggle counter.
// Revision : 1.0
// ============================================================================

module sumador_rizado_fa (
   input  wire logic a,
   input  wire logic b,
   input  wire logic ci,
   output logic      s,
   output logic      co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module sumador_rizado #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 32
) (
   input  wire logic        clk,
   input  wire logic        reset,
   sumador_rizado_if.slave  bus
);
   localparam int C_OUT_W = WIDTH + 2;
   localparam int C_POP_W = $clog2(WIDTH + 3);
   localparam int C_EXT_W = CNT_WIDTH + C_POP_W + 1;
   localparam logic [C_EXT_W-1:0] C_CNT_MAX = {{(C_POP_W+1){1'b0}}, {CNT_WIDTH{1'b1}}};

   logic [WIDTH:0]       w_c;
   logic [WIDTH-1:0]     w_s;
   logic                 w_ovf;
   logic [C_OUT_W-1:0]   w_next_out;
   logic [C_OUT_W-1:0]   w_cur_out;
   logic [C_OUT_W-1:0]   w_toggle;
   logic [C_POP_W-1:0]   w_pop;
   logic [C_EXT_W-1:0]   w_cnt_ext;
   logic [CNT_WIDTH-1:0] w_cnt_next;

   logic [WIDTH-1:0]     r_suma;
   logic                 r_carry;
   logic                 r_ovf;
   logic [CNT_WIDTH-1:0] r_cnt;

   assign w_c[0] = bus.cin;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
         sumador_rizado_fa u_fa (
            .a  (bus.oprA[gi]),
            .b  (bus.oprB[gi]),
            .ci (w_c[gi]),
            .s  (w_s[gi]),
            .co (w_c[gi+1])
         );
      end
   endgenerate

   assign w_ovf      = w_c[WIDTH] ^ w_c[WIDTH-1];
   assign w_next_out = {w_ovf, w_c[WIDTH], w_s};
   assign w_cur_out  = {r_ovf, r_carry, r_suma};
   assign w_toggle   = w_next_out ^ w_cur_out;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < C_OUT_W; i++) begin
         w_pop = w_pop + C_POP_W'(w_toggle[i]);
      end
   end

   // Widened sum so the saturation compare never sees a wrapped value.
   assign w_cnt_ext  = {{(C_POP_W+1){1'b0}}, r_cnt} + C_EXT_W'(w_pop);
   assign w_cnt_next = (w_cnt_ext > C_CNT_MAX) ? {CNT_WIDTH{1'b1}}
                                               : w_cnt_ext[CNT_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_suma  <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_suma  <= w_s;
         r_carry <= w_c[WIDTH];
         r_ovf   <= w_ovf;
         if (bus.clr_cnt) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_next;
         end
      end
   end

   assign bus.Suma         = r_suma;
   assign bus.carry        = r_carry;
   assign bus.ovf          = r_ovf;
   assign bus.transiciones = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_sumador_rizado.sv
`default_nettype none
// ============================================================================
// Module   : tb_sumador_rizado
// Purpose  : Scoreboard bench for sumador_rizado (main and 4-bit-counter copies).
// Revision : 1.0
// ============================================================================
module tb_sumador_rizado;
   logic clk;
   logic reset;
   logic reset2;

   sumador_rizado_if #(.WIDTH(8), .CNT_WIDTH(32)) bus  ();
   sumador_rizado_if #(.WIDTH(8), .CNT_WIDTH(4))  bus2 ();

   sumador_rizado #(.WIDTH(8), .CNT_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   sumador_rizado #(.WIDTH(8), .CNT_WIDTH(4)) dut2 (
      .clk   (clk),
      .reset (reset2),
      .bus   (bus2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [7:0]  sum;
      logic        carry;
      logic        ovf;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  m_sum    = '0;
   logic        m_carry  = 1'b0;
   logic        m_ovf    = 1'b0;
   logic [63:0] m_cnt    = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Drive one cycle, push the model's expectation, then pop and compare after the edge.
   task automatic step(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic clr, input logic rst);
      exp_t        e;
      logic [8:0]  res;
      logic        ov;
      int          pop;
      logic [63:0] nc;
      bus.oprA    = a;
      bus.oprB    = b;
      bus.cin     = ci;
      bus.clr_cnt = clr;
      reset       = rst;
      if (rst) begin
         e = '0;
      end else begin
         res = {1'b0, a} + {1'b0, b} + {8'd0, ci};
         ov  = (a[7] == b[7]) && (res[7] != a[7]);
         pop = $countones({ov, res} ^ {m_ovf, m_carry, m_sum});
         nc  = m_cnt + 64'(pop);
         if (nc > 64'hFFFF_FFFF) nc = 64'hFFFF_FFFF;
         if (clr) nc = '0;
         e.sum   = res[7:0];
         e.carry = res[8];
         e.ovf   = ov;
         e.cnt   = nc[31:0];
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("Suma",         {56'd0, bus.Suma},         {56'd0, e.sum});
      check("carry",        {63'd0, bus.carry},        {63'd0, e.carry});
      check("ovf",          {63'd0, bus.ovf},          {63'd0, e.ovf});
      check("transiciones", {32'd0, bus.transiciones}, {32'd0, e.cnt});
      m_sum   = e.sum;
      m_carry = e.carry;
      m_ovf   = e.ovf;
      m_cnt   = {32'd0, e.cnt};
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      integer      seed;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [31:0] saved;
      logic [31:0] exp2;

      reset        = 1'b1;
      reset2       = 1'b1;
      bus.oprA     = '0;
      bus.oprB     = '0;
      bus.cin      = 1'b0;
      bus.clr_cnt  = 1'b0;
      bus2.oprA    = '0;
      bus2.oprB    = '0;
      bus2.cin     = 1'b0;
      bus2.clr_cnt = 1'b0;

      // Reset held two cycles with nonzero operands, then release.
      step(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
      step(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
      step(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      check("first_cnt", {32'd0, bus.transiciones}, 64'd1);

      step(8'd100, 8'd27,  1'b0, 1'b0, 1'b0);
      step(8'd200, 8'd100, 1'b0, 1'b0, 1'b0);
      step(8'd127, 8'd1,   1'b0, 1'b0, 1'b0);

      step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
      saved = bus.transiciones;
      step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      check("ripple_delta", {32'd0, bus.transiciones - saved}, 64'd9);

      seed = 10;
      for (int i = 0; i < 100; i++) begin
         ra = 8'($random(seed));
         rb = 8'($random(seed));
         step(ra, rb, 1'b0, 1'b0, (i == 50));
      end

      step(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
      saved = bus.transiciones;
      for (int i = 0; i < 10; i++) begin
         step(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
      end
      check("hold_cnt", {32'd0, bus.transiciones}, {32'd0, saved});

      step(8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0);
      step(8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0);

      // Saturation on the 4-bit counter instance.
      @(posedge clk);
      #1;
      reset2 = 1'b0;
      exp2   = 32'd0;
      for (int i = 0; i < 6; i++) begin
         bus2.oprA = (i % 2 == 0) ? 8'hFF : 8'h00;
         @(posedge clk);
         #1;
         exp2 = (exp2 + 32'd8 > 32'd15) ? 32'd15 : exp2 + 32'd8;
         check("sat_suma", {56'd0, bus2.Suma}, (i % 2 == 0) ? 64'hFF : 64'h00);
         check("sat_cnt",  {60'd0, bus2.transiciones}, {32'd0, exp2});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
